// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: conditions both pins, deframes and checks 11-bit frames,
// and folds E0/F0 prefixes into single key events with typematic repeat flagging.
module ps2_key_decoder #(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 20000
) (
   input  logic       CLK100MHZ,
   input  logic       BTNC,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic       key_repeat,
   output logic       frame_err,
   output logic [7:0] err_count
);

   localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [FW-1:0] FiltLast    = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          clk_filt_q, dat_filt_q, clk_prev_q;
   logic [FW-1:0] clk_cnt_q, dat_cnt_q;

   state_e        state_q;
   logic [3:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic          parity_q, stop_q;
   logic [TW-1:0] to_cnt_q;
   logic          ext_pend_q, brk_pend_q;
   logic          held_valid_q, held_ext_q;
   logic [7:0]    held_code_q;

   logic          key_valid_q, key_ext_q, key_break_q, key_repeat_q, frame_err_q;
   logic [7:0]    key_code_q, err_count_q;

   logic          clk_fall, frame_ok, timeout, err_now, held_hit;

   // Two-flop synchronizers; idle level of both PS/2 lines is high.
   always_ff @(posedge CLK100MHZ) begin
      if (BTNC) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], PS2_CLK};
         dat_sync_q <= {dat_sync_q[0], PS2_DATA};
      end
   end

   // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
   always_ff @(posedge CLK100MHZ) begin
      if (BTNC) begin
         clk_filt_q <= 1'b1;
         dat_filt_q <= 1'b1;
         clk_prev_q <= 1'b1;
         clk_cnt_q  <= '0;
         dat_cnt_q  <= '0;
      end else begin
         clk_prev_q <= clk_filt_q;

         if (clk_sync_q[1] == clk_filt_q) begin
            clk_cnt_q <= '0;
         end else if (clk_cnt_q == FiltLast) begin
            clk_filt_q <= clk_sync_q[1];
            clk_cnt_q  <= '0;
         end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
         end

         if (dat_sync_q[1] == dat_filt_q) begin
            dat_cnt_q <= '0;
         end else if (dat_cnt_q == FiltLast) begin
            dat_filt_q <= dat_sync_q[1];
            dat_cnt_q  <= '0;
         end else begin
            dat_cnt_q <= dat_cnt_q + 1'b1;
         end
      end
   end

   assign clk_fall = clk_prev_q & ~clk_filt_q;
   assign frame_ok = (^{shift_q, parity_q}) & stop_q;
   assign timeout  = (state_q == StRecv) && !clk_fall && (to_cnt_q == TimeoutLast);
   assign err_now  = ((state_q == StIdle) && clk_fall && dat_filt_q) || timeout ||
                     ((state_q == StCheck) && !frame_ok);
   assign held_hit = held_valid_q && (held_ext_q == ext_pend_q) && (held_code_q == shift_q);

   always_ff @(posedge CLK100MHZ) begin
      if (BTNC) begin
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         stop_q       <= 1'b0;
         to_cnt_q     <= '0;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         held_valid_q <= 1'b0;
         held_ext_q   <= 1'b0;
         held_code_q  <= '0;
         key_valid_q  <= 1'b0;
         key_code_q   <= '0;
         key_ext_q    <= 1'b0;
         key_break_q  <= 1'b0;
         key_repeat_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_count_q  <= '0;
      end else begin
         key_valid_q <= 1'b0;
         frame_err_q <= err_now;
         if (err_now && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
         end

         unique case (state_q)
            StIdle: begin
               if (clk_fall && !dat_filt_q) begin
                  state_q   <= StRecv;
                  bit_cnt_q <= 4'd1;
                  to_cnt_q  <= '0;
               end
            end

            StRecv: begin
               if (clk_fall) begin
                  to_cnt_q  <= '0;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q <= 4'd8) begin
                     shift_q <= {dat_filt_q, shift_q[7:1]};
                  end else if (bit_cnt_q == 4'd9) begin
                     parity_q <= dat_filt_q;
                  end else begin
                     stop_q  <= dat_filt_q;
                     state_q <= StCheck;
                  end
               end else if (timeout) begin
                  state_q    <= StIdle;
                  ext_pend_q <= 1'b0;
                  brk_pend_q <= 1'b0;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end

            StCheck: begin
               state_q <= StIdle;
               if (!frame_ok) begin
                  ext_pend_q <= 1'b0;
                  brk_pend_q <= 1'b0;
               end else begin
                  case (shift_q)
                     8'hE0: ext_pend_q <= 1'b1;
                     8'hF0: brk_pend_q <= 1'b1;
                     8'h00, 8'hFF: begin
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                     end
                     default: begin
                        key_valid_q <= 1'b1;
                        key_code_q  <= shift_q;
                        key_ext_q   <= ext_pend_q;
                        key_break_q <= brk_pend_q;
                        ext_pend_q  <= 1'b0;
                        brk_pend_q  <= 1'b0;
                        if (brk_pend_q) begin
                           key_repeat_q <= 1'b0;
                           if (held_hit) begin
                              held_valid_q <= 1'b0;
                           end
                        end else begin
                           key_repeat_q <= held_hit;
                           held_valid_q <= 1'b1;
                           held_ext_q   <= ext_pend_q;
                           held_code_q  <= shift_q;
                        end
                     end
                  endcase
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   assign key_valid  = key_valid_q;
   assign key_code   = key_code_q;
   assign key_ext    = key_ext_q;
   assign key_break  = key_break_q;
   assign key_repeat = key_repeat_q;
   assign frame_err  = frame_err_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: frames are driven on the pins, expected strobes
// are queued, and a negedge monitor pops and compares every key_valid/frame_err pulse.
module tb_ps2_key_decoder;

   localparam int unsigned FL = 8;
   localparam int unsigned TO = 200;
   localparam int          HP = 20;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      bit         ext;
      bit         brk;
      bit         rep;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2c;
   logic       ps2d;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       key_repeat;
   logic       frame_err;
   logic [7:0] err_count;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_strobe = 0;
   exp_t sb[$];
   exp_t mon_e;

   ps2_key_decoder #(
      .FILTER_LEN (FL),
      .TIMEOUT_CYC(TO)
   ) dut (
      .CLK100MHZ (clk),
      .BTNC      (rst),
      .PS2_CLK   (ps2c),
      .PS2_DATA  (ps2d),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .key_break (key_break),
      .key_repeat(key_repeat),
      .frame_err (frame_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (key_valid || frame_err)) begin
         n_strobe++;
         check("strobe_exclusive", int'(key_valid & frame_err), 0);
         check("strobe_expected", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("strobe_kind_err", int'(frame_err), int'(mon_e.is_err));
            if (!mon_e.is_err) begin
               check("key_code", int'(key_code), int'(mon_e.code));
               check("key_ext", int'(key_ext), int'(mon_e.ext));
               check("key_break", int'(key_break), int'(mon_e.brk));
               check("key_repeat", int'(key_repeat), int'(mon_e.rep));
            end
            if (mon_e.cyc >= 0) check("strobe_latency", cyc, mon_e.cyc);
         end
      end
   end

   // One bit: data set while clock is high, then a falling edge; optionally queue the
   // expected response timed from this edge.
   task automatic send_bit(input logic b, input bit push, input exp_t e);
      ps2d = b;
      repeat (HP) @(posedge clk);
      #1 ps2c = 1'b0;
      if (push) begin
         e.cyc = cyc + int'(FL) + 4;
         sb.push_back(e);
      end
      repeat (HP) @(posedge clk);
      #1 ps2c = 1'b1;
   endtask

   // kind: 0 = no response, 1 = key event, 2 = frame error
   task automatic send_frame(input logic [7:0] b, input bit bad, input int kind,
                             input logic [7:0] code, input bit ext, input bit brk,
                             input bit rep);
      logic [10:0] fr;
      exp_t        e;
      fr = {1'b1, (~^b) ^ bad, b, 1'b0};
      e.is_err = (kind == 2);
      e.code   = code;
      e.ext    = ext;
      e.brk    = brk;
      e.rep    = rep;
      e.cyc    = 0;
      for (int i = 0; i < 11; i++) begin
         send_bit(fr[i], (i == 10) && (kind != 0), e);
      end
      ps2d = 1'b1;
      repeat (2 * HP) @(posedge clk);
      #1;
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      logic [10:0] fr;
      exp_t        e;
      fr = {1'b1, ~^b, b, 1'b0};
      e  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0};
      for (int i = 0; i < nbits; i++) begin
         send_bit(fr[i], 1'b0, e);
      end
      ps2d = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int   s0;
      exp_t e;
      rst  = 1'b1;
      ps2c = 1'b1;
      ps2d = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_key_valid", int'(key_valid), 0);
      check("reset_key_code", int'(key_code), 0);
      check("reset_flags", int'({key_ext, key_break, key_repeat}), 0);
      check("reset_frame_err", int'(frame_err), 0);
      check("reset_err_count", int'(err_count), 0);
      @(posedge clk);
      #1;

      send_frame(8'h1C, 0, 1, 8'h1C, 0, 0, 0);
      send_frame(8'hF0, 0, 0, 8'h00, 0, 0, 0);
      send_frame(8'h1C, 0, 1, 8'h1C, 0, 1, 0);
      send_frame(8'hE0, 0, 0, 8'h00, 0, 0, 0);
      send_frame(8'h75, 0, 1, 8'h75, 1, 0, 0);
      send_frame(8'hE0, 0, 0, 8'h00, 0, 0, 0);
      send_frame(8'hF0, 0, 0, 8'h00, 0, 0, 0);
      send_frame(8'h75, 0, 1, 8'h75, 1, 1, 0);

      send_frame(8'h1C, 0, 1, 8'h1C, 0, 0, 0);
      send_frame(8'h1C, 0, 1, 8'h1C, 0, 0, 1);
      send_frame(8'hF0, 0, 0, 8'h00, 0, 0, 0);
      send_frame(8'h1C, 0, 1, 8'h1C, 0, 1, 0);
      send_frame(8'h1C, 0, 1, 8'h1C, 0, 0, 0);

      send_frame(8'h1C, 1, 2, 8'h00, 0, 0, 0);
      check("err_count_after_parity", int'(err_count), 1);
      send_frame(8'h32, 0, 1, 8'h32, 0, 0, 0);

      s0 = n_strobe;
      ps2c = 1'b0;
      repeat (5) @(posedge clk);
      #1 ps2c = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check("glitch_no_strobe", n_strobe - s0, 0);
      check("hold_key_code", int'(key_code), 'h32);
      check("err_count_after_glitch", int'(err_count), 1);

      send_partial(8'h4D, 5);
      e = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, -1};
      sb.push_back(e);
      repeat (TO + 100) @(posedge clk);
      #1;
      check("timeout_consumed", sb.size(), 0);
      check("err_count_after_timeout", int'(err_count), 2);
      send_frame(8'h1C, 0, 1, 8'h1C, 0, 0, 0);

      send_partial(8'hF0, 7);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midreset_err_count", int'(err_count), 0);
      check("midreset_key_code", int'(key_code), 0);
      @(posedge clk);
      #1;
      send_frame(8'h1C, 0, 1, 8'h1C, 0, 0, 0);
      check("err_count_after_midreset", int'(err_count), 0);

      ps2d = 1'b1;
      for (int i = 0; i < 260; i++) begin
         repeat (12) @(posedge clk);
         #1 ps2c = 1'b0;
         e = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, -1};
         sb.push_back(e);
         repeat (12) @(posedge clk);
         #1 ps2c = 1'b1;
      end
      repeat (40) @(posedge clk);
      #1;
      check("err_count_saturated", int'(err_count), 255);
      check("hold_after_errors", int'(key_code), 'h1C);
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Front-end stage feeding the keyboard display logic: it turns the raw PS2_CLK/PS2_DATA pins into complete, checked key events, so downstream logic never handles raw bytes or prefix bytes. It synchronizes and glitch-filters both lines, deframes 11-bit PS/2 frames, and checks start, parity and stop bits. It resolves the E0 (extended) and F0 (break) prefixes and flags typematic repeats. Each key event comes out as a single one-cycle `key_valid` strobe.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical samples required before a filtered line changes level
- TIMEOUT_CYC, 20000: maximum cycles allowed between falling edges inside a frame (200 us at 100 MHz)

Ports:
- CLK100MHZ  in  1  system clock; the only clock in the block
- BTNC  in  1  reset, synchronous, active-high
- PS2_CLK  in  1  keyboard clock pin, asynchronous
- PS2_DATA  in  1  keyboard data pin, asynchronous
- key_valid  out  1  one-cycle strobe: new key event
- key_code  out  8  scan code of the event (never E0 or F0)
- key_ext  out  1  event was preceded by E0
- key_break  out  1  event is a release (preceded by F0)
- key_repeat  out  1  make event for the key already held
- frame_err  out  1  one-cycle strobe: frame rejected
- err_count  out  8  count of rejected frames, saturates at 255

## Operation
- **Input conditioning:** each pin passes through a 2-flop synchronizer, then a filter. The filtered level changes only after FILTER_LEN consecutive samples at the new level. A falling edge of the filtered clock samples the filtered data.
- **Frame FSM states:** IDLE, RECV, CHECK.
- **IDLE:**
  - edge with data=0 -> RECV, bit count = 1.
  - edge with data=1 -> frame_err, stay in IDLE.
- **RECV:**
  - bits 1-8 are shifted in LSB first; bit 9 is parity; bit 10 is stop.
  - the edge that captures bit 10 -> CHECK.
- **CHECK** (lasts one cycle, then -> IDLE):
  - frame is valid only if XOR(data[7:0], parity) == 1 and stop == 1.
  - on a bad frame: frame_err pulses, err_count increments (saturating), both pending flags clear, no event.
- **Timeout:** in RECV, a cycle counter is cleared on each edge. If it reaches TIMEOUT_CYC: -> IDLE, frame_err pulses, err_count increments, pending flags clear.
- **Byte decode** (valid frames only):
  - E0 -> set ext_pend, no event.
  - F0 -> set brk_pend, no event.
  - 00 or FF (keyboard error/overrun) -> clear both pending flags, no event, no frame_err.
  - any other byte -> emit an event: key_code = byte, key_ext = ext_pend, key_break = brk_pend. Then clear both pending flags.
- **Repeat tracking:** a held register stores {ext, code} plus a valid bit.
  - make equal to the held key -> key_repeat=1.
  - make for a different key -> replaces the held key, key_repeat=0.
  - break matching the held key -> clears the held register.
  - break never sets key_repeat.
- **Output holding:** key_code, key_ext, key_break and key_repeat are registered and hold their values until the next event.

## Timing
- **Reset values:**
  - key_valid, key_code, key_ext, key_break, key_repeat, frame_err, err_count = 0.
  - filtered lines = 1; FSM = IDLE.
  - pending flags, held register and timeout counter cleared.
- **Latency:** key_valid asserts exactly FILTER_LEN+4 cycles after the stop-bit falling edge on the PS2_CLK pin, given PS2_DATA is stable at least FILTER_LEN+2 cycles before that edge. The latency is constant for every event.
- **Strobes:** key_valid and frame_err are one cycle wide and never asserted in the same cycle. No back-pressure: the consumer must take the event in the strobe cycle.
- **Reset mid-frame:** BTNC discards the partial frame with no event and no frame_err. The first frame whose start bit arrives after reset deasserts decodes normally.
- **Glitches:** pulses on either pin shorter than FILTER_LEN cycles have no effect.
- **Prefix sequences:** E0 F0 xx produces ext=1, brk=1. Prefixes carry across frames only through the pending flags, with no time limit.
- **err_count:** holds at 255 once it saturates; only reset clears it.

## Test plan
- Frame 0x1C (odd parity 0, stop 1) at a 60 us bit period -> one key_valid at stop edge + FILTER_LEN+4, with code=1C, ext=0, brk=0, rep=0.
- Sequence F0, 1C -> exactly one key_valid, code=1C, brk=1. E0 75, then E0 F0 75 -> two events: {ext=1, brk=0} then {ext=1, brk=1}.
- Makes 1C, 1C, then F0 1C, then 1C -> rep values 0, 1, (break) 0, then 0.
- Frame 0x1C with parity=1 -> frame_err pulse, err_count=1, no key_valid. The next good 0x32 frame decodes with code=32.
- 5-cycle low glitch on PS2_CLK in IDLE -> no response. Frame halted after 5 bits for >TIMEOUT_CYC cycles -> one frame_err; the following frame decodes correctly.
- BTNC asserted after bit 6 of an F0 frame, then 0x1C sent -> event code=1C, brk=0, frame_err never pulses.
